// File: rtl/axi_slv_mem.sv
// AXI slave endpoint backed by a word-addressed memory. Independent read and
// write FSMs, one outstanding transaction each, OKAY/SLVERR per burst/beat.
module axi_slv_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [3:0]              awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [3:0]              wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [3:0]              bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [3:0]              arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [3:0]              rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Burst-level errors: reserved burst type, oversize beat, bad WRAP length.
    function automatic logic f_cfg_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((32'd1 << size) > 32'(STRB_W)) ||
               ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                          input logic [7:0] len,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b01:   return addr + incr;
            2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
            default: return addr;
        endcase
    endfunction

    // ---------------- write path ----------------
    w_state_t              r_w_state;
    logic                  r_awready, r_wready, r_bvalid;
    logic [3:0]            r_bid, r_aw_id;
    logic [1:0]            r_bresp, r_aw_burst;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [7:0]            r_aw_len, r_w_beat;
    logic [2:0]            r_aw_size;
    logic                  r_w_over, r_w_err;

    logic [ADDR_WIDTH-1:0] w_aw_word;
    logic                  w_wr_hs, w_wr_last_err, w_wr_err, w_wr_en;
    logic                  w_unused;

    assign w_unused      = ^wid;
    assign w_aw_word     = r_aw_addr >> ADDR_LSB;
    assign w_wr_hs       = r_wready && wvalid;
    // r_w_over marks that beat awlen already passed without wlast.
    assign w_wr_last_err = wlast && (r_w_over || (r_w_beat != r_aw_len));
    assign w_wr_err      = f_cfg_err(r_aw_len, r_aw_size, r_aw_burst) ||
                           (w_aw_word >= DEPTH_A) || w_wr_last_err;
    assign w_wr_en       = w_wr_hs && !w_wr_err;

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) r_mem[w_aw_word[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_state  <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= '0;
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_w_beat   <= '0;
            r_w_over   <= 1'b0;
            r_w_err    <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (awvalid && r_awready) begin
                        r_aw_id    <= awid;
                        r_aw_addr  <= awaddr;
                        r_aw_len   <= awlen;
                        r_aw_size  <= awsize;
                        r_aw_burst <= awburst;
                        r_w_beat   <= '0;
                        r_w_over   <= 1'b0;
                        r_w_err    <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wr_hs) begin
                        r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
                        r_w_beat  <= r_w_beat + 8'd1;
                        r_w_err   <= r_w_err | w_wr_err;
                        if (r_w_beat == r_aw_len) r_w_over <= 1'b1;
                        if (wlast) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bid     <= r_aw_id;
                            r_bresp   <= (r_w_err || w_wr_err) ? 2'b10 : 2'b00;
                            r_w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t              r_r_state;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [3:0]            r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp, r_ar_burst;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len, r_r_beat;
    logic [2:0]            r_ar_size;

    logic                  w_r_idle;
    logic [ADDR_WIDTH-1:0] w_rd_addr, w_rd_word;
    logic [7:0]            w_rd_len, w_r_next_beat;
    logic [2:0]            w_rd_size;
    logic [1:0]            w_rd_burst;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // In idle the fetch targets beat 0 of the incoming AR; otherwise the next beat.
    assign w_r_idle      = (r_r_state == R_IDLE);
    assign w_rd_addr     = w_r_idle ? araddr  : r_ar_addr;
    assign w_rd_len      = w_r_idle ? arlen   : r_ar_len;
    assign w_rd_size     = w_r_idle ? arsize  : r_ar_size;
    assign w_rd_burst    = w_r_idle ? arburst : r_ar_burst;
    assign w_rd_word     = w_rd_addr >> ADDR_LSB;
    assign w_rd_err      = f_cfg_err(w_rd_len, w_rd_size, w_rd_burst) || (w_rd_word >= DEPTH_A);
    assign w_rd_data     = w_rd_err ? '0 : r_mem[w_rd_word[IDX_W-1:0]];
    assign w_r_next_beat = r_r_beat + 8'd1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_r_state  <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_r_beat   <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (arvalid && r_arready) begin
                        r_ar_addr  <= f_next_addr(araddr, arlen, arsize, arburst);
                        r_ar_len   <= arlen;
                        r_ar_size  <= arsize;
                        r_ar_burst <= arburst;
                        r_r_beat   <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= arid;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_err ? 2'b10 : 2'b00;
                        r_rlast    <= (arlen == 8'd0);
                        r_r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_ar_addr <= f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
                            r_r_beat  <= w_r_next_beat;
                            r_rdata   <= w_rd_data;
                            r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
                            r_rlast   <= (w_r_next_beat == r_ar_len);
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem: directed bursts push expected B/R
// responses; a monitor thread pops and compares on every handshake.
module tb_axi_slv_mem;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [3:0]    awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [3:0]    wid = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [3:0]    arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [3:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b1;

    axi_slv_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      qb[$];
    r_exp_t      qr[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", nm, why);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic monitor();
        b_exp_t      eb;
        r_exp_t      er;
        logic        stall_prev;
        logic [38:0] held;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (bvalid && bready) begin
                    if (qb.size() == 0) fail_now("b_unexpected", "got handshake, expected none");
                    else begin
                        eb = qb.pop_front();
                        chk("bid", bid, eb.id);
                        chk("bresp", bresp, eb.resp);
                    end
                end
                if (rvalid && stall_prev) chk("r_stall_stable", {rid, rdata, rresp, rlast}, held);
                if (rvalid && rready) begin
                    if (qr.size() == 0) fail_now("r_unexpected", "got handshake, expected none");
                    else begin
                        er = qr.pop_front();
                        chk("rdata", rdata, er.data);
                        chk("rresp", rresp, er.resp);
                        chk("rlast", rlast, er.last);
                        chk("rid", rid, er.id);
                    end
                end
                stall_prev = rvalid && !rready;
                held = {rid, rdata, rresp, rlast};
            end else stall_prev = 1'b0;
        end
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
        wd[i] = d; ws[i] = s; wl[i] = l;
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
        qr.push_back('{id: id, data: d, resp: resp, last: last});
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int k;
        @(posedge aclk); #1;
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        k = 0;
        do begin @(negedge aclk); k++; end while (!awready && k < 50);
        if (!awready) fail_now("aw_wait", "timeout waiting for awready");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        chk("aw_hs_ready", {awready, wready}, 2'b01);
    endtask

    task automatic do_w(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
            k = 0;
            do begin @(negedge aclk); k++; end while (!wready && k < 50);
            if (!wready) fail_now("w_wait", "timeout waiting for wready");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int n,
                            input logic [1:0] exp_resp, input int bstall);
        int k;
        qb.push_back('{id: id, resp: exp_resp});
        bready = (bstall == 0);
        do_aw(id, a, len, size, burst);
        do_w(n);
        if (bstall > 0) begin
            repeat (bstall) begin
                @(negedge aclk);
                chk("b_stall_valid", bvalid, 1'b1);
                chk("b_stall_resp", bresp, exp_resp);
                chk("b_stall_awready", awready, 1'b0);
            end
            @(posedge aclk); #1;
            bready = 1'b1;
        end
        k = 0;
        while (qb.size() != 0 && k < 50) begin @(posedge aclk); #1; k++; end
        if (qb.size() != 0) begin fail_now("b_wait", "timeout waiting for B"); qb.delete(); end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int k;
        @(posedge aclk); #1;
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        k = 0;
        do begin @(negedge aclk); k++; end while (!arready && k < 50);
        if (!arready) fail_now("ar_wait", "timeout waiting for arready");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        chk("ar_hs_ready", {arready, rvalid}, 2'b01);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic toggle);
        int k;
        rready = 1'b1;
        do_ar(id, a, len, size, burst);
        k = 0;
        while (qr.size() != 0 && k < 200) begin
            if (toggle) rready = ~rready;
            @(posedge aclk); #1;
            k++;
        end
        rready = 1'b1;
        if (qr.size() != 0) begin fail_now("r_wait", "timeout waiting for R"); qr.delete(); end
        else chk("r_done_idle", rvalid, 1'b0);
    endtask

    initial begin
        int k;
        fork monitor(); join_none
        fork
            begin
                repeat (20000) @(posedge aclk);
                fail_now("watchdog", "simulation budget exhausted");
                finish_run();
            end
        join_none

        // Reset values, then readiness one edge after release.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_b", {bvalid, bid, bresp}, 7'd0);
        chk("rst_r", {rvalid, rid, rdata, rresp, rlast}, 40'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_ready_pre", {awready, arready}, 2'b00);
        @(negedge aclk);
        chk("rel_ready_post", {awready, arready}, 2'b11);

        // INCR write and read-back.
        set_beat(0, 32'h11, 4'hF, 1'b0); set_beat(1, 32'h22, 4'hF, 1'b0);
        set_beat(2, 32'h33, 4'hF, 1'b0); set_beat(3, 32'h44, 4'hF, 1'b1);
        do_write(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 4, 2'b00, 0);
        push_r(4'd7, 32'h11, 2'b00, 1'b0); push_r(4'd7, 32'h22, 2'b00, 1'b0);
        push_r(4'd7, 32'h33, 2'b00, 1'b0); push_r(4'd7, 32'h44, 2'b00, 1'b1);
        do_read(4'd7, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);

        // WRAP read: 0x108, 0x10C, 0x100, 0x104.
        push_r(4'd2, 32'h33, 2'b00, 1'b0); push_r(4'd2, 32'h44, 2'b00, 1'b0);
        push_r(4'd2, 32'h11, 2'b00, 1'b0); push_r(4'd2, 32'h22, 2'b00, 1'b1);
        do_read(4'd2, 32'h108, 8'd3, 3'd2, 2'b10, 1'b0);

        // FIXED write, then partial-strobe overwrite.
        set_beat(0, 32'hAAAA1111, 4'hF, 1'b0); set_beat(1, 32'hBBBB2222, 4'hF, 1'b0);
        set_beat(2, 32'hCCCC3333, 4'hF, 1'b1);
        do_write(4'd1, 32'h200, 8'd2, 3'd2, 2'b00, 3, 2'b00, 0);
        set_beat(0, 32'hFFFFFFFF, 4'h3, 1'b1);
        do_write(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 1, 2'b00, 0);
        push_r(4'd1, 32'hCCCCFFFF, 2'b00, 1'b0); push_r(4'd1, 32'hCCCCFFFF, 2'b00, 1'b1);
        do_read(4'd1, 32'h200, 8'd1, 3'd2, 2'b00, 1'b0);

        // Error cases.
        set_beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
        do_write(4'd4, 32'h1000, 8'd0, 3'd2, 2'b01, 1, 2'b10, 0);
        push_r(4'd4, 32'h0, 2'b10, 1'b1);
        do_read(4'd4, 32'h1000, 8'd0, 3'd2, 2'b01, 1'b0);
        do_write(4'd6, 32'h100, 8'd0, 3'd2, 2'b11, 1, 2'b10, 0);
        push_r(4'd6, 32'h11, 2'b00, 1'b1);
        do_read(4'd6, 32'h100, 8'd0, 3'd2, 2'b01, 1'b0);
        push_r(4'd6, 32'h0, 2'b10, 1'b1);
        do_read(4'd6, 32'h100, 8'd0, 3'd2, 2'b11, 1'b0);
        push_r(4'd6, 32'h0, 2'b10, 1'b1);
        do_read(4'd6, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0);
        set_beat(0, 32'h12345678, 4'hF, 1'b1);
        do_write(4'd8, 32'h300, 8'd0, 3'd2, 2'b01, 1, 2'b00, 0);
        set_beat(0, 32'h0, 4'hF, 1'b1);
        do_write(4'd8, 32'h300, 8'd1, 3'd2, 2'b01, 1, 2'b10, 0);
        push_r(4'd8, 32'h12345678, 2'b00, 1'b1);
        do_read(4'd8, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0);
        set_beat(0, 32'h5555AAAA, 4'hF, 1'b0); set_beat(1, 32'h66666666, 4'hF, 1'b1);
        do_write(4'd9, 32'h304, 8'd0, 3'd2, 2'b01, 2, 2'b10, 0);
        push_r(4'd9, 32'h5555AAAA, 2'b00, 1'b1);
        do_read(4'd9, 32'h304, 8'd0, 3'd2, 2'b01, 1'b0);
        set_beat(0, 32'h77777777, 4'hF, 1'b0); set_beat(1, 32'h88888888, 4'hF, 1'b1);
        do_write(4'd10, 32'hFFC, 8'd1, 3'd2, 2'b01, 2, 2'b10, 0);
        push_r(4'd10, 32'h77777777, 2'b00, 1'b0); push_r(4'd10, 32'h0, 2'b10, 1'b1);
        do_read(4'd10, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0);

        // Backpressure on B and R.
        set_beat(0, 32'h01, 4'hF, 1'b0); set_beat(1, 32'h02, 4'hF, 1'b1);
        do_write(4'd11, 32'h500, 8'd1, 3'd2, 2'b01, 2, 2'b00, 5);
        push_r(4'd12, 32'h11, 2'b00, 1'b0); push_r(4'd12, 32'h22, 2'b00, 1'b0);
        push_r(4'd12, 32'h33, 2'b00, 1'b0); push_r(4'd12, 32'h44, 2'b00, 1'b1);
        do_read(4'd12, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);

        // Reset during beat 2 of an 8-beat read.
        for (int i = 0; i < 8; i++) set_beat(i, 32'h10000000 + i, 4'hF, i == 7);
        do_write(4'd3, 32'h400, 8'd7, 3'd2, 2'b01, 8, 2'b00, 0);
        push_r(4'd3, 32'h10000000, 2'b00, 1'b0); push_r(4'd3, 32'h10000001, 2'b00, 1'b0);
        rready = 1'b1;
        do_ar(4'd3, 32'h400, 8'd7, 3'd2, 2'b01);
        k = 0;
        while (qr.size() != 0 && k < 50) begin @(posedge aclk); #1; k++; end
        if (qr.size() != 0) begin fail_now("rst_r_wait", "timeout before beat 2"); qr.delete(); end
        rready = 1'b0;
        @(negedge aclk);
        chk("rst_mid_beat2", {rvalid, rdata}, {1'b1, 32'h10000002});
        #1 aresetn = 1'b0;
        #1;
        chk("rst_mid_out", {rvalid, arready, rlast, rdata}, 35'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_mid_arready_pre", arready, 1'b0);
        @(negedge aclk);
        chk("rst_mid_arready_post", arready, 1'b1);
        for (int i = 0; i < 8; i++) push_r(4'd13, 32'h10000000 + i, 2'b00, i == 7);
        do_read(4'd13, 32'h400, 8'd7, 3'd2, 2'b01, 1'b0);
        push_r(4'd14, 32'h11, 2'b00, 1'b1);
        do_read(4'd14, 32'h100, 8'd0, 3'd2, 2'b01, 1'b0);

        repeat (2) @(posedge aclk);
        finish_run();
    end
endmodule
